// File: rtl/coalescing_write_buffer_pkg.sv
// Shared types for the coalescing write buffer: queue entry, FSM states, mask helper.
package coalescing_write_buffer_pkg;

    // Entry fields are sized for the widest supported configuration; narrower
    // instances zero-extend on write and truncate on read.
    localparam int unsigned MAX_ADDRESS_WIDTH = 64;
    localparam int unsigned MAX_DATA_WIDTH    = 128;
    localparam int unsigned MAX_MASK_WIDTH    = MAX_DATA_WIDTH / 8;

    typedef struct packed {
        logic [MAX_ADDRESS_WIDTH-1:0] address;
        logic [MAX_DATA_WIDTH-1:0]    data;
        logic [MAX_MASK_WIDTH-1:0]    mask;
    } entry_t;

    typedef enum logic [1:0] {C_IDLE, C_FLUSH, C_BUS, C_ACK} cpu_state_t;
    typedef enum logic [1:0] {D_IDLE, D_REQ, D_GAP} drain_state_t;

    // True when every byte lane below width is enabled.
    function automatic logic mask_full(input logic [MAX_MASK_WIDTH-1:0] mask,
                                       input int unsigned width);
        logic full;
        full = 1'b1;
        for (int unsigned i = 0; i < MAX_MASK_WIDTH; i++) begin
            if (i < width && !mask[i]) full = 1'b0;
        end
        return full;
    endfunction

endpackage

// File: rtl/coalescing_write_buffer_store.sv
// Circular entry storage with push/pop/merge and youngest-match search.
module write_buffer_store
    import coalescing_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    localparam int unsigned MW = DATA_WIDTH / 8,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic                     i_merge,
    input  logic                     i_pop,
    input  logic [ADDRESS_WIDTH-1:0] i_address,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    input  logic [MW-1:0]            i_wmask,
    input  logic [PW-1:0]            i_read_index,
    output entry_t                   o_head_c,
    output entry_t                   o_read_entry_c,
    output logic [CW-1:0]            o_count,
    output logic [CW-1:0]            o_count_next_c,
    output logic                     o_youngest_match_c,
    output logic                     o_hit_c,
    output logic [PW-1:0]            o_hit_index_c,
    output logic                     o_hit_full_c
);

    entry_t        mem [DEPTH];
    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [PW-1:0] youngest;
    logic [PW-1:0] idx;
    entry_t        new_entry;
    entry_t        merged_entry;

    assign youngest           = tail - PW'(1);
    assign o_head_c           = mem[head];
    assign o_read_entry_c     = mem[i_read_index];
    assign o_count_next_c     = o_count + CW'(i_push) - CW'(i_pop);
    assign o_youngest_match_c = (o_count != '0) &&
                                (mem[youngest].address == MAX_ADDRESS_WIDTH'(i_address));
    assign o_hit_full_c       = mask_full(mem[o_hit_index_c].mask, MW);

    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        o_hit_c       = 1'b0;
        o_hit_index_c = '0;
        idx           = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if (CW'(i) < o_count && mem[idx].address == MAX_ADDRESS_WIDTH'(i_address)) begin
                o_hit_c       = 1'b1;
                o_hit_index_c = idx;
            end
        end
    end

    // Build a fresh entry and the byte-merged version of the youngest entry.
    always_comb begin
        new_entry.address = MAX_ADDRESS_WIDTH'(i_address);
        new_entry.data    = MAX_DATA_WIDTH'(i_wdata);
        new_entry.mask    = MAX_MASK_WIDTH'(i_wmask);
        merged_entry      = mem[youngest];
        for (int unsigned b = 0; b < MW; b++) begin
            if (i_wmask[b]) merged_entry.data[b*8 +: 8] = i_wdata[b*8 +: 8];
        end
        merged_entry.mask = merged_entry.mask | new_entry.mask;
    end

    // Pointer and occupancy bookkeeping; wraps naturally at power-of-two depth.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            head    <= '0;
            tail    <= '0;
            o_count <= '0;
        end else begin
            if (i_push) tail <= tail + PW'(1);
            if (i_pop)  head <= head + PW'(1);
            o_count <= o_count_next_c;
        end
    end

    // Entry storage writes.
    always_ff @(posedge i_clock) begin
        if (i_push) begin
            mem[tail] <= new_entry;
        end else if (i_merge) begin
            mem[youngest] <= merged_entry;
        end
    end

endmodule

// File: rtl/coalescing_write_buffer.sv
// Posted-write buffer between CPU data port and system bus with youngest-entry merge and read forwarding.
module coalescing_write_buffer
    import coalescing_write_buffer_pkg::*;
#(
    parameter int unsigned DEPTH         = 16,
    parameter int unsigned ADDRESS_WIDTH = 32,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter bit          FORWARD       = 1'b1,
    localparam int unsigned MW = DATA_WIDTH / 8,
    localparam int unsigned PW = $clog2(DEPTH),
    localparam int unsigned CW = PW + 1
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    output logic                     o_empty,
    output logic                     o_full,
    input  logic                     i_cached,
    output logic                     o_bus_rw,
    output logic                     o_bus_request,
    input  logic                     i_bus_ready,
    output logic [ADDRESS_WIDTH-1:0] o_bus_address,
    input  logic [DATA_WIDTH-1:0]    i_bus_rdata,
    output logic [DATA_WIDTH-1:0]    o_bus_wdata,
    output logic [MW-1:0]            o_bus_wmask,
    input  logic                     i_rw,
    input  logic                     i_request,
    output logic                     o_ready,
    input  logic [ADDRESS_WIDTH-1:0] i_address,
    output logic [DATA_WIDTH-1:0]    o_rdata,
    input  logic [DATA_WIDTH-1:0]    i_wdata,
    input  logic [MW-1:0]            i_wmask
);

    cpu_state_t    cpu_state;
    drain_state_t  drain_state;
    entry_t        head;
    entry_t        read_entry;
    logic [CW-1:0] count;
    logic [CW-1:0] count_next_c;
    logic          youngest_match_c;
    logic          hit_c;
    logic [PW-1:0] hit_index_c;
    logic          hit_full_c;
    logic          write_c;
    logic          merge_c;
    logic          push_c;
    logic          pop_c;
    logic          head_busy_c;
    logic          forward_c;

    write_buffer_store #(
        .DEPTH        (DEPTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_store (
        .i_clock           (i_clock),
        .i_reset           (i_reset),
        .i_push            (push_c),
        .i_merge           (merge_c),
        .i_pop             (pop_c),
        .i_address         (i_address),
        .i_wdata           (i_wdata),
        .i_wmask           (i_wmask),
        .i_read_index      (hit_index_c),
        .o_head_c          (head),
        .o_read_entry_c    (read_entry),
        .o_count           (count),
        .o_count_next_c    (count_next_c),
        .o_youngest_match_c(youngest_match_c),
        .o_hit_c           (hit_c),
        .o_hit_index_c     (hit_index_c),
        .o_hit_full_c      (hit_full_c)
    );

    // The head is committed to the bus once the drain leaves D_IDLE, so a lone
    // entry in D_IDLE/D_REQ must not be merged into.
    assign head_busy_c = (count == CW'(1)) && (drain_state != D_GAP);
    assign pop_c       = (drain_state == D_REQ) && i_bus_ready;
    assign write_c     = (cpu_state == C_IDLE) && i_request && i_rw && i_cached;
    assign merge_c     = write_c && youngest_match_c && !head_busy_c;
    assign push_c      = write_c && !merge_c && ((count < CW'(DEPTH)) || pop_c);
    assign forward_c   = FORWARD && !i_rw && hit_c && hit_full_c;

    // CPU-side FSM: buffer, forward, or flush-then-pass-through.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cpu_state <= C_IDLE;
            o_ready   <= 1'b0;
            o_rdata   <= '0;
        end else begin
            o_ready <= 1'b0;
            case (cpu_state)
                C_IDLE: begin
                    if (i_request) begin
                        if (i_rw && i_cached) begin
                            if (merge_c || push_c) begin
                                cpu_state <= C_ACK;
                                o_ready   <= 1'b1;
                            end
                        end else if (forward_c) begin
                            o_rdata   <= DATA_WIDTH'(read_entry.data);
                            cpu_state <= C_ACK;
                            o_ready   <= 1'b1;
                        end else begin
                            cpu_state <= C_FLUSH;
                        end
                    end
                end
                C_FLUSH: if (o_empty) cpu_state <= C_BUS;
                C_BUS: begin
                    if (i_bus_ready) begin
                        if (!i_rw) o_rdata <= i_bus_rdata;
                        cpu_state <= C_ACK;
                        o_ready   <= 1'b1;
                    end
                end
                C_ACK:   cpu_state <= C_IDLE;
                default: cpu_state <= C_IDLE;
            endcase
        end
    end

    // Drain FSM plus registered occupancy flags.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            drain_state <= D_IDLE;
            o_empty     <= 1'b1;
            o_full      <= 1'b0;
        end else begin
            case (drain_state)
                D_IDLE:  if (count != '0) drain_state <= D_REQ;
                D_REQ:   if (i_bus_ready) drain_state <= D_GAP;
                D_GAP:   drain_state <= D_IDLE;
                default: drain_state <= D_IDLE;
            endcase
            o_empty <= (count_next_c == '0) &&
                       ((drain_state == D_GAP) || (drain_state == D_IDLE && count == '0));
            o_full  <= (count_next_c == CW'(DEPTH));
        end
    end

    // Bus master registers, shared by pass-through and drain (never both active).
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_bus_request <= 1'b0;
            o_bus_rw      <= 1'b0;
            o_bus_address <= '0;
            o_bus_wdata   <= '0;
            o_bus_wmask   <= '0;
        end else if (cpu_state == C_FLUSH && o_empty) begin
            o_bus_request <= 1'b1;
            o_bus_rw      <= i_rw;
            o_bus_address <= i_address;
            o_bus_wdata   <= i_wdata;
            o_bus_wmask   <= i_rw ? i_wmask : '1;
        end else if (cpu_state == C_BUS) begin
            if (i_bus_ready) o_bus_request <= 1'b0;
        end else if (drain_state == D_IDLE && count != '0) begin
            o_bus_request <= 1'b1;
            o_bus_rw      <= 1'b1;
            o_bus_address <= ADDRESS_WIDTH'(head.address);
            o_bus_wdata   <= DATA_WIDTH'(head.data);
            o_bus_wmask   <= MW'(head.mask);
        end else if (pop_c) begin
            o_bus_request <= 1'b0;
        end
    end

endmodule

// File: tb/tb_coalescing_write_buffer.sv
// Scoreboard bench: expected bus transactions and CPU acks are queued by stimulus, checked by monitors.
module tb_coalescing_write_buffer;

    logic        i_clock = 1'b0;
    logic        i_reset;
    logic        o_empty, o_full, i_cached, o_bus_rw, o_bus_request, i_bus_ready;
    logic [31:0] o_bus_address, i_bus_rdata, o_bus_wdata;
    logic [3:0]  o_bus_wmask;
    logic        i_rw, i_request, o_ready;
    logic [31:0] i_address, o_rdata, i_wdata;
    logic [3:0]  i_wmask;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] rdata;
    } bus_exp_t;

    typedef struct {
        logic        rw;
        logic [31:0] rdata;
    } cpu_exp_t;

    bus_exp_t bus_q[$];
    cpu_exp_t cpu_q[$];
    int total = 0;
    int bad = 0;
    int bus_seen = 0;
    int ack_count = 0;
    logic bus_hold;

    coalescing_write_buffer #(
        .DEPTH(16), .ADDRESS_WIDTH(32), .DATA_WIDTH(32), .FORWARD(1'b1)
    ) dut (
        .i_clock(i_clock), .i_reset(i_reset), .o_empty(o_empty), .o_full(o_full),
        .i_cached(i_cached), .o_bus_rw(o_bus_rw), .o_bus_request(o_bus_request),
        .i_bus_ready(i_bus_ready), .o_bus_address(o_bus_address), .i_bus_rdata(i_bus_rdata),
        .o_bus_wdata(o_bus_wdata), .o_bus_wmask(o_bus_wmask), .i_rw(i_rw),
        .i_request(i_request), .o_ready(o_ready), .i_address(i_address),
        .o_rdata(o_rdata), .i_wdata(i_wdata), .i_wmask(i_wmask)
    );

    initial forever #5 i_clock = ~i_clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    task automatic expect_bus(input logic rw, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wmask, input logic [31:0] rdata);
        bus_exp_t e;
        e.rw = rw; e.addr = addr; e.wdata = wdata; e.wmask = wmask; e.rdata = rdata;
        bus_q.push_back(e);
    endtask

    // Issue one CPU request and hold it until o_ready; exp_lat 0 skips the latency check.
    task automatic cpu_op(input logic rw, input logic cached, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask,
                          input logic [31:0] exp_rdata, input int exp_lat);
        cpu_exp_t c;
        int cyc;
        c.rw = rw; c.rdata = exp_rdata;
        cpu_q.push_back(c);
        @(negedge i_clock);
        i_request = 1'b1; i_rw = rw; i_cached = cached;
        i_address = addr; i_wdata = wdata; i_wmask = wmask;
        cyc = 0;
        do begin
            @(negedge i_clock);
            cyc++;
        end while (!o_ready && cyc < 1000);
        if (!o_ready) fail_now("cpu_ack_timeout");
        else if (exp_lat > 0) check("ack_latency", 64'(cyc), 64'(exp_lat));
        i_request = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int cyc;
        cyc = 0;
        while ((bus_q.size() != 0 || cpu_q.size() != 0 || !o_empty || o_bus_request) && cyc < 2000) begin
            @(negedge i_clock);
            cyc++;
        end
        if (cyc >= 2000) begin
            total++;
            bad++;
            $display("FAIL %s: idle timeout, %0d bus items pending", name, bus_q.size());
        end
        @(negedge i_clock);
    endtask

    // Bus slave: compares each handshake against the scoreboard and returns one-cycle ready.
    initial begin
        bus_exp_t e;
        i_bus_ready = 1'b0;
        i_bus_rdata = '0;
        forever begin
            @(negedge i_clock);
            if (i_bus_ready) begin
                i_bus_ready = 1'b0;
            end else if (o_bus_request && !bus_hold && !i_reset) begin
                bus_seen++;
                if (bus_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_bus: addr %0h rw %0b", o_bus_address, o_bus_rw);
                end else begin
                    e = bus_q.pop_front();
                    check("bus_rw", 64'(o_bus_rw), 64'(e.rw));
                    check("bus_addr", 64'(o_bus_address), 64'(e.addr));
                    if (e.rw) begin
                        check("bus_wdata", 64'(o_bus_wdata), 64'(e.wdata));
                        check("bus_wmask", 64'(o_bus_wmask), 64'(e.wmask));
                    end
                    i_bus_rdata = e.rdata;
                end
                i_bus_ready = 1'b1;
            end
        end
    end

    // CPU ack monitor: single-cycle pulse and read data.
    initial begin
        cpu_exp_t c;
        logic prev;
        prev = 1'b0;
        forever begin
            @(negedge i_clock);
            if (o_ready) begin
                ack_count++;
                check("ready_pulse", 64'(prev), 64'(0));
                if (cpu_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_ack: rdata %0h", o_rdata);
                end else begin
                    c = cpu_q.pop_front();
                    if (!c.rw) check("cpu_rdata", 64'(o_rdata), 64'(c.rdata));
                end
            end
            prev = o_ready;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks0;
        int seen0;
        i_reset = 1'b1; i_request = 1'b0; i_rw = 1'b0; i_cached = 1'b0;
        i_address = '0; i_wdata = '0; i_wmask = '0; bus_hold = 1'b0;
        repeat (3) @(negedge i_clock);
        i_reset = 1'b0;
        @(negedge i_clock);
        check("reset_empty", 64'(o_empty), 64'(1));
        check("reset_full", 64'(o_full), 64'(0));
        check("reset_ready", 64'(o_ready), 64'(0));
        check("reset_bus_request", 64'(o_bus_request), 64'(0));
        check("reset_rdata", 64'(o_rdata), 64'(0));
        check("reset_bus_address", 64'(o_bus_address), 64'(0));

        // Merge into youngest entry while an older entry holds the bus.
        bus_hold = 1'b1;
        expect_bus(1'b1, 32'h0000_0FFF, 32'h1234_5678, 4'hF, 32'h0);
        expect_bus(1'b1, 32'h0000_1001, 32'hB0AB_1111, 4'b1110, 32'h0);
        cpu_op(1'b1, 1'b1, 32'h0000_0FFF, 32'h1234_5678, 4'hF, 32'h0, 1);
        cpu_op(1'b1, 1'b1, 32'h0000_1001, 32'hB00B_1111, 4'b1010, 32'h0, 1);
        cpu_op(1'b1, 1'b1, 32'h0000_1001, 32'h00AB_0000, 4'b0100, 32'h0, 1);
        bus_hold = 1'b0;
        wait_idle("merge");

        // Fill to 16 with the bus stalled; the 17th must wait for a pop.
        bus_hold = 1'b1;
        for (int i = 0; i < 16; i++) begin
            expect_bus(1'b1, 32'h100 + 32'(i), 32'(i + 1) * 32'h0101_0101, 4'hF, 32'h0);
            cpu_op(1'b1, 1'b1, 32'h100 + 32'(i), 32'(i + 1) * 32'h0101_0101, 4'hF, 32'h0, 1);
        end
        @(negedge i_clock);
        check("full_flag", 64'(o_full), 64'(1));
        check("full_not_empty", 64'(o_empty), 64'(0));
        expect_bus(1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF, 32'h0);
        fork
            cpu_op(1'b1, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'hF, 32'h0, 0);
            begin
                acks0 = ack_count;
                repeat (6) @(negedge i_clock);
                check("full_stall_acks", 64'(ack_count - acks0), 64'(0));
                bus_hold = 1'b0;
            end
        join
        wait_idle("full_drain");
        check("full_cleared", 64'(o_full), 64'(0));

        // Forward hit on a full-mask entry: no bus read.
        bus_hold = 1'b1;
        seen0 = bus_seen;
        expect_bus(1'b1, 32'h2003, 32'hB00B_3333, 4'hF, 32'h0);
        cpu_op(1'b1, 1'b1, 32'h2003, 32'hB00B_3333, 4'hF, 32'h0, 1);
        cpu_op(1'b0, 1'b1, 32'h2003, 32'h0, 4'h0, 32'hB00B_3333, 1);
        // Partial-mask hit forces a flush then a bus read.
        expect_bus(1'b1, 32'h4005, 32'h1111_2222, 4'b0011, 32'h0);
        expect_bus(1'b0, 32'h4005, 32'h0, 4'h0, 32'hCAFE_F00D);
        cpu_op(1'b1, 1'b1, 32'h4005, 32'h1111_2222, 4'b0011, 32'h0, 1);
        fork
            cpu_op(1'b0, 1'b1, 32'h4005, 32'h0, 4'h0, 32'hCAFE_F00D, 0);
            begin
                repeat (4) @(negedge i_clock);
                check("flush_read_stalled", 64'(cpu_q.size()), 64'(1));
                bus_hold = 1'b0;
            end
        join
        wait_idle("forward");
        check("forward_bus_count", 64'(bus_seen - seen0), 64'(3));

        // Uncached write waits behind three queued writes.
        bus_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            expect_bus(1'b1, 32'h3001 + 32'(i), 32'hA0A0_0000 + 32'(i), 4'hF, 32'h0);
            cpu_op(1'b1, 1'b1, 32'h3001 + 32'(i), 32'hA0A0_0000 + 32'(i), 4'hF, 32'h0, 1);
        end
        expect_bus(1'b1, 32'h3004, 32'h4444_4444, 4'b0110, 32'h0);
        fork
            cpu_op(1'b1, 1'b0, 32'h3004, 32'h4444_4444, 4'b0110, 32'h0, 0);
            begin
                repeat (3) @(negedge i_clock);
                check("uncached_not_empty", 64'(o_empty), 64'(0));
                bus_hold = 1'b0;
            end
        join
        wait_idle("uncached");

        // Reset mid-drain discards the queue and drops the bus request at once.
        bus_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cpu_op(1'b1, 1'b1, 32'h500 + 32'(i), 32'h5555_0000 + 32'(i), 4'hF, 32'h0, 1);
        end
        repeat (2) @(negedge i_clock);
        check("predrain_request", 64'(o_bus_request), 64'(1));
        #2 i_reset = 1'b1;
        #1;
        check("reset_drops_request", 64'(o_bus_request), 64'(0));
        check("reset_sets_empty", 64'(o_empty), 64'(1));
        @(negedge i_clock);
        i_reset = 1'b0;
        bus_hold = 1'b0;
        seen0 = bus_seen;
        expect_bus(1'b1, 32'h5006, 32'h6666_6666, 4'hF, 32'h0);
        cpu_op(1'b1, 1'b1, 32'h5006, 32'h6666_6666, 4'hF, 32'h0, 1);
        wait_idle("after_reset");
        repeat (5) @(negedge i_clock);
        check("writes_after_reset", 64'(bus_seen - seen0), 64'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
